// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: button codes, display-select
// encodings and loader FSM state encodings.
package calc_pkg;

    localparam logic [3:0] CODE_SHOW_R0 = 4'd1;
    localparam logic [3:0] CODE_SHOW_R1 = 4'd2;
    localparam logic [3:0] CODE_SHOW_RS = 4'd4;
    localparam logic [3:0] CODE_LD_R0   = 4'd9;
    localparam logic [3:0] CODE_LD_R1   = 4'd10;
    localparam logic [3:0] CODE_LD_RS   = 4'd12;
    localparam logic [3:0] CODE_CLR     = 4'd15;

    localparam logic [1:0] DISP_ALU = 2'd0;
    localparam logic [1:0] DISP_R0  = 2'd1;
    localparam logic [1:0] DISP_R1  = 2'd2;
    localparam logic [1:0] DISP_RS  = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_COMMIT = 2'd1;
    localparam state_t ST_HELD   = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; stable_code follows the
// synchronised code only after it has been unchanged for DB_CYCLES cycles.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] bt,
    output logic [W-1:0] stable_code
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [W-1:0]  sync1, sync2, prev;
    logic [CW-1:0] cnt, cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != prev)
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            cnt         <= '0;
            stable_code <= '0;
        end else begin
            sync1 <= bt;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_nxt;
            // accept on the edge the counter reaches its limit; re-writing while saturated is harmless
            if (sync2 == prev && cnt_nxt == CNT_MAX)
                stable_code <= sync2;
        end
    end

endmodule

// File: rtl/btn_operand_loader.sv
// Debounced button decoder that loads operands/opcode from the switches and
// selects the display source. Define BTN_CLEAR_CODE_EN to make code 15 clear r0/r1/rs.
module btn_operand_loader
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int DATA_W    = 12,
    parameter int OP_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        bt,
    input  logic [DATA_W-1:0] switch,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [OP_W-1:0]   rs,
    output logic [1:0]        disp_sel,
    output logic              load_pulse,
    output logic              code_valid
);
    logic [3:0] stable_code;
    state_t     state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .W(4)) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .bt          (bt),
        .stable_code (stable_code)
    );

    assign code_valid = (state != ST_IDLE);

    // Actions are registered on entry to COMMIT so results and load_pulse
    // appear together during the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            r0         <= '0;
            r1         <= '0;
            rs         <= '0;
            disp_sel   <= DISP_ALU;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (stable_code != 4'd0) begin
                        state <= ST_COMMIT;
                        case (stable_code)
                            CODE_LD_R0:   begin r0 <= switch;           load_pulse <= 1'b1; end
                            CODE_LD_R1:   begin r1 <= switch;           load_pulse <= 1'b1; end
                            CODE_LD_RS:   begin rs <= switch[OP_W-1:0]; load_pulse <= 1'b1; end
                            CODE_SHOW_R0: disp_sel <= DISP_R0;
                            CODE_SHOW_R1: disp_sel <= DISP_R1;
                            CODE_SHOW_RS: disp_sel <= DISP_RS;
`ifdef BTN_CLEAR_CODE_EN
                            CODE_CLR: begin
                                r0         <= '0;
                                r1         <= '0;
                                rs         <= '0;
                                load_pulse <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_COMMIT: state <= ST_HELD;
                ST_HELD: begin
                    // one action per press: only a full release re-arms
                    if (stable_code == 4'd0) begin
                        state    <= ST_IDLE;
                        disp_sel <= DISP_ALU;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_operand_loader.sv
// Scoreboard bench for btn_operand_loader with DB_CYCLES=4.
module tb_btn_operand_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  bt;
    logic [11:0] switch;
    logic [11:0] r0, r1;
    logic [3:0]  rs;
    logic [1:0]  disp_sel;
    logic        load_pulse, code_valid;

    typedef struct packed {
        logic [11:0] r0;
        logic [11:0] r1;
        logic [3:0]  rs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   lp_count = 0;
    logic lp_prev = 1'b0;

    btn_operand_loader #(.DB_CYCLES(4), .DATA_W(12), .OP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bt         (bt),
        .switch     (switch),
        .r0         (r0),
        .r1         (r1),
        .rs         (rs),
        .disp_sel   (disp_sel),
        .load_pulse (load_pulse),
        .code_valid (code_valid)
    );

    always #5 clk = ~clk;

    // monitor: every load_pulse pops one expected register set
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && load_pulse) begin
            lp_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_load: got r0=%0d r1=%0d rs=%0d, expected no load", r0, r1, rs);
            end else begin
                e = sb.pop_front();
                if (r0 !== e.r0 || r1 !== e.r1 || rs !== e.rs) begin
                    errors++;
                    $display("FAIL sb_load: got r0=%0d r1=%0d rs=%0d, expected r0=%0d r1=%0d rs=%0d",
                             r0, r1, rs, e.r0, e.r1, e.rs);
                end
            end
            checks++;
            if (lp_prev) begin
                errors++;
                $display("FAIL lp_consecutive: got load_pulse=1 twice, expected single-cycle strobe");
            end
        end
        lp_prev = load_pulse;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code, input logic [11:0] sw);
        switch = sw;
        bt     = code;
        wait_cyc(12);
        bt = 4'd0;
        wait_cyc(12);
    endtask

    initial begin
        int lp0;
        rst_n  = 1'b0;
        bt     = 4'd9;
        switch = 12'd201;
        wait_cyc(4);
        check("rst_r0", r0, 0);
        check("rst_r1", r1, 0);
        check("rst_rs", rs, 0);
        check("rst_disp", disp_sel, 0);
        check("rst_lp", load_pulse, 0);
        check("rst_cv", code_valid, 0);

        // held button re-debounced after reset: r0 visible after 2+4+1 edges
        sb.push_back('{12'd201, 12'd0, 4'd0});
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rel_r0_early", r0, 0);
        check("rel_lp_early", load_pulse, 0);
        @(posedge clk);
        #1;
        check("rel_r0", r0, 201);
        check("rel_lp", load_pulse, 1);
        check("rel_cv", code_valid, 1);
        @(negedge clk);
        bt = 4'd0;
        wait_cyc(12);
        check("rel_cv_off", code_valid, 0);

        // bounce shorter than the debounce window
        lp0    = lp_count;
        switch = 12'd77;
        for (int i = 0; i < 5; i++) begin
            bt = 4'd9;
            wait_cyc(2);
            bt = 4'd0;
            wait_cyc(2);
            check("bounce_cv", code_valid, 0);
        end
        wait_cyc(12);
        check("bounce_r0", r0, 201);
        check("bounce_lp", lp_count - lp0, 0);

        // load sequence
        lp0 = lp_count;
        sb.push_back('{12'd201, 12'd0, 4'd3});
        press(4'd12, 12'd3);
        sb.push_back('{12'd201, 12'd40, 4'd3});
        press(4'd10, 12'd40);
        sb.push_back('{12'd201, 12'd40, 4'd3});
        press(4'd9, 12'd201);
        check("seq_r0", r0, 201);
        check("seq_r1", r1, 40);
        check("seq_rs", rs, 3);
        check("seq_lp", lp_count - lp0, 3);

        // display select
        lp0 = lp_count;
        bt = 4'd2;
        wait_cyc(12);
        check("disp_r1", disp_sel, 2);
        check("disp_cv", code_valid, 1);
        bt = 4'd0;
        wait_cyc(12);
        check("disp_rel", disp_sel, 0);
        check("disp_rel_cv", code_valid, 0);
        bt = 4'd4;
        wait_cyc(12);
        check("disp_rs", disp_sel, 3);
        bt = 4'd0;
        wait_cyc(12);
        check("disp_rel2", disp_sel, 0);
        check("disp_lp", lp_count - lp0, 0);

        // no re-trigger while held
        lp0    = lp_count;
        sb.push_back('{12'd201, 12'd40, 4'd3});
        switch = 12'd201;
        bt     = 4'd9;
        wait_cyc(12);
        switch = 12'd55;
        wait_cyc(4);
        bt = 4'd10;
        wait_cyc(12);
        check("hold_cv", code_valid, 1);
        bt = 4'd0;
        wait_cyc(12);
        check("hold_r0", r0, 201);
        check("hold_r1", r1, 40);
        check("hold_lp", lp_count - lp0, 1);

        // code 15
        lp0 = lp_count;
`ifdef BTN_CLEAR_CODE_EN
        sb.push_back('{12'd0, 12'd0, 4'd0});
        press(4'd15, 12'd99);
        check("clr_r0", r0, 0);
        check("clr_r1", r1, 0);
        check("clr_rs", rs, 0);
        check("clr_lp", lp_count - lp0, 1);
`else
        press(4'd15, 12'd99);
        check("clr_r0", r0, 201);
        check("clr_r1", r1, 40);
        check("clr_rs", rs, 3);
        check("clr_lp", lp_count - lp0, 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_operand_loader.md
Name: btn_operand_loader

Overview:
- Front-end input stage of the binary calculator; sits directly upstream of the ALU/display top level.
- Synchronises and debounces the 4 push-buttons and decodes the stable button code into one-shot actions.
- Registers the 12-bit switch value into operand A (r0), operand B (r1) or the opcode (rs), and drives the display-select code.
- Downstream logic consumes only clean, registered values; no latches.

Parameters:
- DB_CYCLES, 1000000, number of clk cycles a button code must stay unchanged to be accepted (10 ms at 100 MHz).
- DATA_W, 12, operand and switch width.
- OP_W, 4, opcode width; taken from switch[OP_W-1:0].

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bt  in  4  raw push-button inputs, asynchronous to clk.
- switch  in  DATA_W  slide switches; sampled only at commit.
- r0  out  DATA_W  operand A register.
- r1  out  DATA_W  operand B register.
- rs  out  OP_W  opcode register.
- disp_sel  out  2  0 = ALU result, 1 = r0, 2 = r1, 3 = rs.
- load_pulse  out  1  one-cycle strobe on every register write.
- code_valid  out  1  high while a debounced nonzero code is held.

Behaviour:
- Reset (rst_n low, async): r0=0, r1=0, rs=0, disp_sel=0, load_pulse=0, code_valid=0, FSM=IDLE, debounce counter=0, synchroniser flops=0.
- Synchroniser: 2-flop per bit on bt; switch is not synchronised (static during commit by usage).
- Debounce: counter clears whenever the synchronised code differs from the previous cycle's code. When counter reaches DB_CYCLES-1, stable_code <= synchronised code. Counter saturates while the code is unchanged.
- Latency: button edge to stable_code update = 2 + DB_CYCLES cycles. Commit occurs the cycle after stable_code becomes nonzero.
- FSM states: IDLE, COMMIT, HELD.
- IDLE -> COMMIT when stable_code != 0.
- COMMIT lasts exactly 1 cycle, then -> HELD. Action in COMMIT depends on the code:
  - 9: r0 <= switch, load_pulse=1.
  - 10: r1 <= switch, load_pulse=1.
  - 12: rs <= switch[OP_W-1:0], load_pulse=1.
  - 1: disp_sel <= 1. 2: disp_sel <= 2. 4: disp_sel <= 3.
  - Any other code: no action, load_pulse=0.
- HELD -> IDLE only when stable_code == 0; disp_sel returns to 0 in that same transition.
- In HELD, a change to a different nonzero code performs no action. The user must release before the next action, so there is exactly one action per press.
- code_valid = 1 in COMMIT and HELD.
- Bounces shorter than DB_CYCLES never change stable_code, and therefore never cause a commit.
- Reset asserted mid-press: everything clears. After release of reset, a button still held is re-debounced and commits once.
- load_pulse is never high in two consecutive cycles.

Optional Feature:
- Macro: BTN_CLEAR_CODE_EN.
- Defined: stable code 15 in COMMIT clears r0, r1 and rs to 0 and asserts load_pulse.
- Not defined: code 15 is treated as an unknown code and causes no action.

Decomposition:
- Package calc_pkg holds:
  - Button code constants: CODE_SHOW_R0=1, CODE_SHOW_R1=2, CODE_SHOW_RS=4, CODE_LD_R0=9, CODE_LD_R1=10, CODE_LD_RS=12, CODE_CLR=15.
  - disp_sel encodings.
  - FSM state enum.
- Sub-module btn_debounce contains the synchroniser and debounce counter, parameterised by DB_CYCLES and width 4, with output stable_code.
- The loader FSM and registers stay in btn_operand_loader.

Test Plan (DB_CYCLES=4):
- Reset: hold rst_n low with bt=9 -> all outputs 0. Release reset with switch=201 -> r0=201 after 2+4+1 cycles, one load_pulse.
- Bounce: bt toggles 0/9 every 2 cycles for 20 cycles, then 0 -> r0 unchanged, load_pulse never asserted.
- Load sequence: bt=12/sw=3, release; bt=10/sw=40, release; bt=9/sw=201, release -> rs=3, r1=40, r0=201, exactly 3 load_pulses.
- Display: hold bt=2 -> disp_sel=2 while held, 0 after release-debounce. Hold bt=4 -> disp_sel=3.
- No re-trigger: hold bt=9, change sw 201->55 during HELD, then switch bt to 10 without release -> r0=201, r1 unchanged, single load_pulse.
- BTN_CLEAR_CODE_EN: with r0=201, press bt=15 -> r0=r1=rs=0 with one load_pulse. Without the macro -> registers unchanged.
